// File: rtl/ov7670_sccb_config.sv
// OV7670 boot-time register programmer: walks a {reg,data} ROM and writes each entry over SCCB (3-phase write).
// Optional OV_SWRESET_EN: issue COM7 soft reset (12/80) after power-up and idle SWRST_WAIT clocks before the table.
module ov7670_sccb_config #(
    parameter int          QTR_DIV        = 80,
    parameter int          POWERUP_CYCLES = 32000,
    parameter int          GAP_QTRS       = 8,
    parameter int          SWRST_WAIT     = 32000,
    parameter logic [7:0]  DEV_ID         = 8'h42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       sioc,
    output logic       siod_oe,
    output logic       busy,
    output logic       done,
    output logic [4:0] cfg_idx
);

    localparam int WAIT_MAX = (POWERUP_CYCLES > SWRST_WAIT) ? POWERUP_CYCLES : SWRST_WAIT;
    localparam int QN_MAX   = (GAP_QTRS > 108) ? GAP_QTRS : 108;
    localparam int QC_W     = $clog2(QTR_DIV) + 1;
    localparam int WC_W     = $clog2(WAIT_MAX) + 1;
    localparam int QN_W     = $clog2(QN_MAX) + 1;

`ifdef OV_SWRESET_EN
    typedef enum logic [2:0] {S_PWRUP, S_SWRST, S_LOAD, S_START, S_BITS, S_STOP, S_GAP, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_PWRUP, S_LOAD, S_START, S_BITS, S_STOP, S_GAP, S_DONE} state_t;
`endif

    state_t            state, state_nx;
    logic [QC_W-1:0]   qcnt;
    logic [QN_W-1:0]   qn;
    logic [WC_W-1:0]   wcnt;
    logic [26:0]       sh;
    logic [15:0]       entry;
    logic              tick;
    logic              sioc_d, oe_d;
    logic              sw_pend;

    function automatic logic [15:0] rom(input logic [4:0] idx);
        case (idx)
            5'd0:    rom = 16'h1214;
            5'd1:    rom = 16'h40D0;
            5'd2:    rom = 16'h8C00;
            5'd3:    rom = 16'h1101;
            5'd4:    rom = 16'h0C04;
            5'd5:    rom = 16'h3E19;
            5'd6:    rom = 16'h7211;
            5'd7:    rom = 16'h73F1;
            5'd8:    rom = 16'hA202;
            default: rom = 16'hFFFF;
        endcase
    endfunction

    assign tick  = (qcnt == QC_W'(QTR_DIV - 1));
    assign entry = sw_pend ? 16'h1280 : rom(cfg_idx);
    assign busy  = (state != S_DONE);
    assign done  = (state == S_DONE);

    always_comb begin
        state_nx = state;
        sioc_d   = 1'b1;
        oe_d     = 1'b0;
        case (state)
            S_PWRUP: if (wcnt == WC_W'(POWERUP_CYCLES - 1)) state_nx = S_LOAD;
`ifdef OV_SWRESET_EN
            S_SWRST: if (wcnt == WC_W'(SWRST_WAIT - 1)) state_nx = S_LOAD;
`endif
            S_LOAD:  state_nx = (!sw_pend && entry == 16'hFFFF) ? S_DONE : S_START;
            S_START: begin
                // SDA falls in q1 while SCL is still high, then SCL drops
                sioc_d = (qn < QN_W'(2));
                oe_d   = (qn != '0);
                if (tick && qn == QN_W'(3)) state_nx = S_BITS;
            end
            S_BITS: begin
                sioc_d = (qn[1:0] == 2'd1) || (qn[1:0] == 2'd2);
                oe_d   = ~sh[26];
                if (tick && qn == QN_W'(107)) state_nx = S_STOP;
            end
            S_STOP: begin
                sioc_d = (qn != '0);
                oe_d   = (qn < QN_W'(2));
                if (tick && qn == QN_W'(3)) state_nx = S_GAP;
            end
            S_GAP: begin
                if (tick && qn == QN_W'(GAP_QTRS - 1)) begin
`ifdef OV_SWRESET_EN
                    state_nx = sw_pend ? S_SWRST : S_LOAD;
`else
                    state_nx = S_LOAD;
`endif
                end
            end
            S_DONE:  if (start) state_nx = S_LOAD;
            default: state_nx = S_PWRUP;
        endcase
    end

    // Pins are registered so decode glitches never reach the bus; reset still idles them asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_PWRUP;
            qcnt    <= '0;
            qn      <= '0;
            wcnt    <= '0;
            cfg_idx <= '0;
            sh      <= '0;
            sioc    <= 1'b1;
            siod_oe <= 1'b0;
        end else begin
            state   <= state_nx;
            sioc    <= sioc_d;
            siod_oe <= oe_d;
            if (state_nx != state) begin
                qcnt <= '0;
                qn   <= '0;
                wcnt <= '0;
            end else begin
                wcnt <= wcnt + 1'b1;
                if (tick) begin
                    qcnt <= '0;
                    qn   <= qn + 1'b1;
                end else begin
                    qcnt <= qcnt + 1'b1;
                end
            end
            // Each byte carries a trailing 1 so the 9th (ACK) bit releases SIOD.
            if (state == S_LOAD)
                sh <= {DEV_ID, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
            else if (state == S_BITS && tick && qn[1:0] == 2'd3)
                sh <= {sh[25:0], 1'b1};
            if (state == S_GAP && state_nx == S_LOAD)
                cfg_idx <= cfg_idx + 1'b1;
            else if (state == S_DONE && start)
                cfg_idx <= '0;
        end
    end

`ifdef OV_SWRESET_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sw_pend <= 1'b1;
        else if (state == S_GAP && state_nx == S_SWRST)
            sw_pend <= 1'b0;
    end
`else
    assign sw_pend = 1'b0;
`endif

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Bench for ov7670_sccb_config: an SCCB slave model decodes bus writes and compares them with the expected register table.
module tb_ov7670_sccb_config;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       sioc, siod_oe, busy, done;
    logic [4:0] cfg_idx;

    ov7670_sccb_config #(
        .QTR_DIV(2), .POWERUP_CYCLES(10), .GAP_QTRS(2), .SWRST_WAIT(20), .DEV_ID(8'h42)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sioc(sioc), .siod_oe(siod_oe),
        .busy(busy), .done(done), .cfg_idx(cfg_idx)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Slave model: decodes START/bits/STOP from the wired-AND line, optionally ACKs
    logic [23:0] got_q[$];
    logic [23:0] sh_m;
    int          bitcnt = 0;
    bit          in_frame = 0, ack_drv = 0, nack = 0;
    logic        samp = 1'b1, prev_scl = 1'b1, prev_sda = 1'b1;
    int          viol = 0;
    int          last_stop = 0;
    int          gap_first = -1;

    always @(negedge clk) begin
        logic scl, sda;
        scl = sioc;
        sda = ~(siod_oe | ack_drv);
        if (!rst) begin
            in_frame = 0; bitcnt = 0; ack_drv = 0;
            sda = ~siod_oe;
        end else if (prev_scl && scl && prev_sda && !sda) begin
            if (in_frame && bitcnt != 0) viol++;
            in_frame = 1; bitcnt = 0; sh_m = '0; nack = bit'($urandom_range(0, 1));
            if (got_q.size() == 1 && gap_first < 0) gap_first = cyc - last_stop;
        end else if (prev_scl && scl && !prev_sda && sda) begin
            if (in_frame && bitcnt == 27) begin
                got_q.push_back(sh_m);
                last_stop = cyc;
            end else viol++;
            in_frame = 0;
        end else if (!prev_scl && scl && in_frame && bitcnt < 27) begin
            if (bitcnt % 9 == 8) chk("ack_bit_released", 32'(siod_oe), 32'd0);
            else sh_m = {sh_m[22:0], sda};
            samp = sda;
            bitcnt++;
        end else if (prev_scl && !scl && in_frame) begin
            if (bitcnt > 0 && sda !== samp) viol++;
            ack_drv = (bitcnt % 9 == 8) && !nack;
            sda = ~(siod_oe | ack_drv);
        end
        prev_scl = scl;
        prev_sda = sda;
    end

    // Reference: the sensor table as whole 3-byte writes, optionally preceded by the soft reset
    task automatic compare_frames(input string tag, input bit with_sw);
        logic [15:0] tbl [9] = '{16'h1214, 16'h40D0, 16'h8C00, 16'h1101, 16'h0C04,
                                 16'h3E19, 16'h7211, 16'h73F1, 16'hA202};
        logic [23:0] exp_q[$];
        if (with_sw) exp_q.push_back({8'h42, 16'h1280});
        foreach (tbl[i]) exp_q.push_back({8'h42, tbl[i]});
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        chk({tag, "_bus_violations"}, 32'(viol), 32'd0);
    endtask

    task automatic run_to_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin ok = 1; break; end
            if ($urandom_range(0, 63) == 0) start = 1'b1;
        end
        start = 1'b0;
    endtask

    bit with_sw;
    bit ok;
    bit idle_ok;
    int n;

    initial begin
`ifdef OV_SWRESET_EN
        with_sw = 1;
`else
        with_sw = 0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sioc", 32'(sioc), 32'd1);
        chk("rst_oe", 32'(siod_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_idx", 32'(cfg_idx), 32'd0);

        @(posedge clk); #1 rst = 1'b1;
        idle_ok = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(sioc && !siod_oe && busy)) idle_ok = 0;
        end
        chk("pwrup_idle", 32'(idle_ok), 32'd1);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (siod_oe) begin ok = 1; break; end
        end
        chk("first_start_seen", 32'(ok), 32'd1);
        chk("first_start_sioc_high", 32'(sioc), 32'd1);

        run_to_done(20000, ok);
        chk("run1_done_reached", 32'(ok), 32'd1);
        @(negedge clk);
        chk("run1_busy", 32'(busy), 32'd0);
        chk("run1_done", 32'(done), 32'd1);
        chk("run1_idx", 32'(cfg_idx), 32'd9);
        compare_frames("run1", with_sw);
        if (with_sw) chk("swrst_gap_ge20", 32'(gap_first >= 20), 32'd1);

        // Restart from DONE: no power-up wait, no soft reset
        got_q.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_idx", 32'(cfg_idx), 32'd0);
        n = 0;
        while (!siod_oe && n < 100) begin @(negedge clk); n++; end
        chk("restart_no_pwrup", 32'(n < 10), 32'd1);
        run_to_done(20000, ok);
        chk("run2_done_reached", 32'(ok), 32'd1);
        compare_frames("run2", 0);

        // Abort with reset during the data byte of the third write
        got_q.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ok = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (got_q.size() == 2 && in_frame && bitcnt >= 19 && bitcnt <= 25) begin ok = 1; break; end
        end
        chk("abort_point_reached", 32'(ok), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("abort_sioc", 32'(sioc), 32'd1);
        chk("abort_oe", 32'(siod_oe), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        got_q.delete();
        #1 rst = 1'b1;
        run_to_done(20000, ok);
        chk("run3_done_reached", 32'(ok), 32'd1);
        chk("run3_idx", 32'(cfg_idx), 32'd9);
        compare_frames("run3", with_sw);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
